// File: rtl/brush_stamper.sv
// Paint-RAM write stage: stamps a clipped square brush per command, one pixel per clock on port 0.
// Optional full-screen clear sweep is built only when PAINT_CLEAR_EN is defined.
module brush_stamper #(
    parameter int                    H_RES       = 640,
    parameter int                    V_RES       = 480,
    parameter int                    X_WIDTH     = 10,
    parameter int                    Y_WIDTH     = 9,
    parameter int                    ADDR_WIDTH  = 19,
    parameter int                    DATA_WIDTH  = 4,
    parameter int                    BRUSH_R     = 2,
    parameter logic [DATA_WIDTH-1:0] CLEAR_COLOR = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [X_WIDTH-1:0]    cmd_x,
    input  logic [Y_WIDTH-1:0]    cmd_y,
    input  logic [DATA_WIDTH-1:0] cmd_color,
    input  logic                  clear_req,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic                  busy,
    output logic                  done
);
    localparam int CW = ((X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH) + 1;
    localparam logic signed [CW-1:0]   R_S    = CW'(BRUSH_R);
    localparam logic signed [CW-1:0]   X_MAX  = CW'(H_RES - 1);
    localparam logic signed [CW-1:0]   Y_MAX  = CW'(V_RES - 1);
    localparam logic [ADDR_WIDTH-1:0]  H_STEP = ADDR_WIDTH'(H_RES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STAMP  = 2'd1,
        FINISH = 2'd2
`ifdef PAINT_CLEAR_EN
        , CLEAR = 2'd3
`endif
    } state_t;

    // Saturate a signed coordinate into [0, hi].
    function automatic logic signed [CW-1:0] sat(input logic signed [CW-1:0] v,
                                                 input logic signed [CW-1:0] hi);
        if (v[CW-1])     return '0;
        else if (v > hi) return hi;
        else             return v;
    endfunction

    state_t                  state_q;
    logic [X_WIDTH-1:0]      col_q, c0_q, c1_q;
    logic [Y_WIDTH-1:0]      row_q, r1_q;
    logic [ADDR_WIDTH-1:0]   base_q, addr_q;
    logic [DATA_WIDTH-1:0]   color_q, wdata_q;
    logic                    cmd_ready_q, cs_q, busy_q, done_q;

    logic signed [CW-1:0]    xs, ys;
    logic [X_WIDTH-1:0]      c0_d, c1_d;
    logic [Y_WIDTH-1:0]      r0_d, r1_d;
    logic [ADDR_WIDTH-1:0]   base_d, first_d;
    logic                    oor_d, accept;

    assign xs      = signed'(CW'(cmd_x));
    assign ys      = signed'(CW'(cmd_y));
    assign c0_d    = X_WIDTH'(sat(xs - R_S, X_MAX));
    assign c1_d    = X_WIDTH'(sat(xs + R_S, X_MAX));
    assign r0_d    = Y_WIDTH'(sat(ys - R_S, Y_MAX));
    assign r1_d    = Y_WIDTH'(sat(ys + R_S, Y_MAX));
    // The only multiply happens once per command, never inside the pixel loop.
    assign base_d  = ADDR_WIDTH'(r0_d) * H_STEP;
    assign first_d = base_d + ADDR_WIDTH'(c0_d);
    assign oor_d   = (cmd_x >= X_WIDTH'(H_RES)) || (cmd_y >= Y_WIDTH'(V_RES));
    assign accept  = cmd_valid && cmd_ready_q;

`ifdef PAINT_CLEAR_EN
    localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(H_RES * V_RES - 1);
    logic pend_q;
`else
    logic unused_clear_cfg;
    assign unused_clear_cfg = clear_req ^ (|CLEAR_COLOR);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            cs_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef PAINT_CLEAR_EN
            pend_q      <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
`ifdef PAINT_CLEAR_EN
                    if (pend_q) begin
                        state_q     <= CLEAR;
                        pend_q      <= 1'b0;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        cs_q        <= 1'b1;
                        addr_q      <= '0;
                        wdata_q     <= CLEAR_COLOR;
                    end else
`endif
                    if (accept) begin
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        color_q     <= cmd_color;
                        if (oor_d) begin
                            state_q <= FINISH;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= STAMP;
                            c0_q    <= c0_d;
                            c1_q    <= c1_d;
                            r1_q    <= r1_d;
                            col_q   <= c0_d;
                            row_q   <= r0_d;
                            base_q  <= base_d;
                            addr_q  <= first_d;
                            wdata_q <= cmd_color;
                            cs_q    <= 1'b1;
                        end
                    end
`ifdef PAINT_CLEAR_EN
                    else begin
                        cmd_ready_q <= !clear_req;
                    end
`endif
                end
                STAMP: begin
                    if (col_q == c1_q) begin
                        if (row_q == r1_q) begin
                            state_q <= FINISH;
                            cs_q    <= 1'b0;
                            addr_q  <= '0;
                            wdata_q <= '0;
                            done_q  <= 1'b1;
                        end else begin
                            row_q  <= row_q + 1'b1;
                            col_q  <= c0_q;
                            base_q <= base_q + H_STEP;
                            addr_q <= base_q + H_STEP + ADDR_WIDTH'(c0_q);
                        end
                    end else begin
                        col_q  <= col_q + 1'b1;
                        addr_q <= addr_q + 1'b1;
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
`ifdef PAINT_CLEAR_EN
                    cmd_ready_q <= !(pend_q || clear_req);
`else
                    cmd_ready_q <= 1'b1;
`endif
                end
`ifdef PAINT_CLEAR_EN
                CLEAR: begin
                    if (addr_q == LAST_PIX) begin
                        state_q <= FINISH;
                        cs_q    <= 1'b0;
                        addr_q  <= '0;
                        wdata_q <= '0;
                        done_q  <= 1'b1;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
`endif
                default: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                    cs_q        <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
`ifdef PAINT_CLEAR_EN
            // Requests during a sweep are dropped; one already pending and being serviced is not re-armed.
            if (clear_req && (state_q != CLEAR) && !((state_q == IDLE) && pend_q))
                pend_q <= 1'b1;
`endif
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign ram_cs    = cs_q;
    assign ram_we    = cs_q;
    assign ram_oe    = 1'b0;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_brush_stamper.sv
// Bench for brush_stamper: queue-based pixel model checked every cycle, plus literal address/latency pins.
module tb_brush_stamper;
    localparam int H = 640;
    localparam int V = 480;

    logic        clk = 1'b0;
    logic        reset_n, cmd_valid, clear_req;
    logic [9:0]  cmd_x;
    logic [8:0]  cmd_y;
    logic [3:0]  cmd_color;
    logic        cmd_ready, ram_cs, ram_we, ram_oe, busy, done;
    logic [18:0] ram_addr;
    logic [3:0]  ram_wdata;

    brush_stamper dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_color(cmd_color), .clear_req(clear_req),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_cs(ram_cs), .ram_we(ram_we),
        .ram_oe(ram_oe), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       cs;
        int       addr;
        int       data;
        bit       dn;
    } rec_t;

    rec_t expq[$];
    rec_t cur;
    bit   act_b;
    bit   chk_en = 1'b1;
    int   n_chk = 0, n_fail = 0;
    int   cyc = 0;
    int   wr_cnt, first_addr, last_addr, last_wr_cyc, done_cyc;
    int   acc_cyc[$];
    int   addrs[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string nm, longint act, longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected per-cycle behaviour of one command: every in-screen pixel of the brush, row-major, then done.
    function automatic void model_cmd(int x, int y, int c);
        if (x < H && y < V) begin
            for (int dy = -2; dy <= 2; dy++)
                for (int dx = -2; dx <= 2; dx++)
                    if (x + dx >= 0 && x + dx < H && y + dy >= 0 && y + dy < V)
                        expq.push_back('{cs: 1'b1, addr: (y + dy) * H + (x + dx), data: c, dn: 1'b0});
        end
        expq.push_back('{cs: 1'b0, addr: 0, data: 0, dn: 1'b1});
    endfunction

    always @(negedge clk) begin
        if (ram_cs && ram_we) begin
            if (wr_cnt == 0) first_addr = ram_addr;
            wr_cnt++;
            last_addr = ram_addr;
            last_wr_cyc = cyc;
            addrs.push_back(ram_addr);
        end
        if (done) done_cyc = cyc;
        if (chk_en) begin
            if (!reset_n) begin
                expq.delete();
                check("rst_cs", ram_cs, 0);
                check("rst_we", ram_we, 0);
                check("rst_addr", ram_addr, 0);
                check("rst_wdata", ram_wdata, 0);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_ready", cmd_ready, 1);
            end else begin
                act_b = (expq.size() > 0);
                if (act_b) cur = expq.pop_front();
                else       cur = '{cs: 1'b0, addr: 0, data: 0, dn: 1'b0};
                check("cs", ram_cs, cur.cs);
                check("we", ram_we, cur.cs);
                check("oe", ram_oe, 0);
                check("wdata", ram_wdata, cur.cs ? cur.data : 0);
                if (cur.cs) check("addr", ram_addr, cur.addr);
                check("done", done, cur.dn);
                check("busy", busy, act_b);
                check("ready", cmd_ready, !act_b);
                if (cmd_valid && cmd_ready) begin
                    model_cmd(cmd_x, cmd_y, cmd_color);
                    acc_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic clear_obs();
        wr_cnt = 0; first_addr = -1; last_addr = -1; last_wr_cyc = -1; done_cyc = -1;
        acc_cyc.delete(); addrs.delete();
    endtask

    task automatic wait_ready(string nm);
        bit got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (cmd_ready) got = 1'b1;
        end
        check(nm, got, 1);
    endtask

    task automatic send(int x, int y, int c);
        @(posedge clk); #2;
        cmd_valid = 1'b1; cmd_x = 10'(x); cmd_y = 9'(y); cmd_color = 4'(c);
        wait_ready("send_timeout");
        @(posedge clk); #2;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(string nm);
        bit got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        check(nm, got, 1);
    endtask

    int exp3[9] = '{0, 1, 2, 640, 641, 642, 1280, 1281, 1282};

    initial begin
        reset_n = 1'b1; cmd_valid = 1'b0; clear_req = 1'b0;
        cmd_x = '0; cmd_y = '0; cmd_color = '0;
        clear_obs();
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        check("reset_ready", cmd_ready, 1);
        check("reset_busy", busy, 0);

        // Interior brush
        clear_obs();
        send(100, 50, 'hA);
        wait_done("t2_done_timeout");
        @(posedge clk); #2;
        check("t2_writes", wr_cnt, 25);
        check("t2_first", first_addr, 30818);
        check("t2_last", last_addr, 33382);
        check("t2_done_lat", done_cyc - last_wr_cyc, 1);

        // Top-left corner clip
        clear_obs();
        send(0, 0, 'h3);
        wait_done("t3_done_timeout");
        @(posedge clk); #2;
        check("t3_writes", wr_cnt, 9);
        for (int i = 0; i < 9; i++)
            check($sformatf("t3_addr%0d", i), (i < addrs.size()) ? addrs[i] : -1, exp3[i]);

        // Bottom-right corner clip
        clear_obs();
        send(639, 479, 'hF);
        wait_done("t4a_done_timeout");
        @(posedge clk); #2;
        check("t4a_writes", wr_cnt, 9);
        check("t4a_first", first_addr, 305917);
        check("t4a_last", last_addr, 307199);

        // Out-of-range centre
        clear_obs();
        send(700, 10, 'h5);
        wait_done("t4b_done_timeout");
        @(posedge clk); #2;
        check("t4b_writes", wr_cnt, 0);
        check("t4b_done_lat", done_cyc - ((acc_cyc.size() > 0) ? acc_cyc[0] : -100), 1);

        // Back-to-back with cmd_valid held
        clear_obs();
        @(posedge clk); #2;
        cmd_valid = 1'b1; cmd_x = 10'd0; cmd_y = 9'd0; cmd_color = 4'h3;
        wait_ready("t5_first_timeout");
        @(posedge clk); #2;
        cmd_x = 10'd320; cmd_y = 9'd240; cmd_color = 4'h7;
        wait_ready("t5_second_timeout");
        @(posedge clk); #2;
        cmd_valid = 1'b0;
        wait_done("t5_done_timeout");
        @(posedge clk); #2;
        check("t5_accepts", acc_cyc.size(), 2);
        check("t5_gap", (acc_cyc.size() == 2) ? acc_cyc[1] - acc_cyc[0] : -1, 11);
        check("t5_writes", wr_cnt, 34);

        // Reset in the middle of a stamp
        clear_obs();
        send(200, 100, 'h2);
        repeat (4) @(posedge clk);
        #2 reset_n = 1'b0;
        @(negedge clk);
        check("t1_cs", ram_cs, 0);
        check("t1_busy", busy, 0);
        @(posedge clk); #2;
        reset_n = 1'b1;
        clear_obs();
        repeat (5) @(negedge clk);
        check("t1_no_writes", wr_cnt, 0);
        check("t1_ready", cmd_ready, 1);

`ifdef PAINT_CLEAR_EN
        // Clear deferred behind a stamp, then taking priority over a waiting command
        clear_obs();
        send(100, 50, 'hA);
        @(posedge clk); #2 clear_req = 1'b1;
        @(posedge clk); #2 clear_req = 1'b0;
        wait_done("t6_stamp_timeout");
        chk_en = 1'b0;
        check("t6_stamp_writes", wr_cnt, 25);
        cmd_valid = 1'b1; cmd_x = 10'd5; cmd_y = 9'd5; cmd_color = 4'h1;
        begin
            bit got = 1'b0;
            for (int i = 0; i < 5 && !got; i++) begin
                @(negedge clk);
                if (ram_cs) got = 1'b1;
            end
            check("t6_clear_start", got, 1);
        end
        for (int k = 0; k < 200; k++) begin
            check("t6_clr_addr", ram_addr, k);
            check("t6_clr_data", ram_wdata, 0);
            check("t6_clr_ready", cmd_ready, 0);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        @(posedge clk); #2 reset_n = 1'b0;
        @(posedge clk); #2 reset_n = 1'b1;
        chk_en = 1'b1;
`else
        // clear_req has no effect in this build
        clear_obs();
        @(posedge clk); #2 clear_req = 1'b1;
        @(posedge clk); #2 clear_req = 1'b0;
        repeat (10) @(negedge clk);
        check("t6_clear_ignored", wr_cnt, 0);
        check("t6_ready", cmd_ready, 1);
`endif
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
